stage5_lane_scheduler: RTL
==========================

# stage5_lane_scheduler

Dispatch controller for the three stage-5 field-extraction lanes. It accepts one message descriptor per cycle, assigns it round-robin to a free lane, and drives `message_en` and the per-lane `message_mux_control_m1..m3` selects that gate extraction of the MC1 field (and sibling fields) from `message_1..3`. It holds each lane until the downstream stage returns a per-lane done, and force-releases lanes that time out.

## Interface
Parameters:
- `MUX_W`, 4: width of a mux-control / message-type code; equals `message_mux_control_width.
- `MUX_DEFAULT`, 0: code meaning "no message"; equals `message_mux_defaut.
- `TIMEOUT`, 64: maximum cycles a lane stays ACTIVE without a done. Must be ≥ 2.
- `CNT_W`, 16: width of the saturating statistics counters.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `msg_valid`  in  1  descriptor present.
- `msg_type`  in  MUX_W  message type code; this value is forwarded as the lane mux control.
- `msg_ready`  out  1  the scheduler can accept a descriptor this cycle.
- `lane_done`  in  3  bit N: lane N+1 has finished its message; 1-cycle pulse.
- `message_en`  out  1  at least one lane is ACTIVE.
- `message_mux_control_m1`, `message_mux_control_m2`, `message_mux_control_m3`  out  MUX_W each  per-lane select; `MUX_DEFAULT` when the lane is IDLE.
- `lane_timeout`  out  3  1-cycle pulse when lane N+1 is force-released.
- `drop_cnt`  out  CNT_W  number of descriptors discarded because their type was `MUX_DEFAULT`; saturating.
- `timeout_cnt`  out  CNT_W  total lane timeouts; saturating.

## Operation
- **Per-lane FSM.** Each lane has two states, IDLE and ACTIVE, plus a registered type and a timeout counter `tcnt`.
- **msg_ready.**
  - When the presented `msg_type == MUX_DEFAULT`, `msg_ready = 1`.
  - Otherwise, `msg_ready` is the OR of the registered lane-IDLE flags.
  - `msg_ready` depends only on registered state and `msg_type`; there is no path from `msg_valid`.
- **Dropping.** If `msg_valid & msg_ready` and `msg_type == MUX_DEFAULT`, the descriptor is discarded: no lane is granted and `drop_cnt` increments (saturating).
- **Grant.**
  - On `msg_valid & msg_ready` with a non-default type, grant the first IDLE lane found scanning from `rr_ptr` (values 0..2, wrapping).
  - The granted lane goes IDLE→ACTIVE and latches `msg_type`; its `tcnt` is cleared to 0.
  - `rr_ptr` becomes (granted index + 1) mod 3.
- **Release.** For an ACTIVE lane:
  - If `lane_done[N]` is high, the lane goes to IDLE.
  - Else if `tcnt == TIMEOUT-1`, the lane goes to IDLE, pulses `lane_timeout[N]`, and `timeout_cnt` increments (saturating; several simultaneous timeouts add their count).
  - Otherwise `tcnt` increments.
- **Done/timeout priority.** When done and the timeout condition occur in the same cycle, done wins: no timeout pulse and no count.
- **Done on an IDLE lane** is ignored.
- **Lane reuse.** A lane released in cycle t is not grantable in cycle t, because ready and grant use registered state. It is grantable in cycle t+1.
- **Output decode.** `message_mux_control_mN` = latched type when ACTIVE, else `MUX_DEFAULT`. `message_en` = OR of the ACTIVE flags. Both are driven directly from registers.
- **Reset** (`rst_n` low, asynchronous, at any time including mid-message):
  - All lanes IDLE; `rr_ptr = 0`; all `tcnt = 0`.
  - `message_en = 0`; all mux controls = `MUX_DEFAULT`; `lane_timeout = 0`; `drop_cnt = 0`; `timeout_cnt = 0`.
  - `msg_ready` then reflects all-idle, i.e. it is 1.
  - In-flight messages are abandoned with no timeout pulse.

## Timing
- **Accept latency.** A descriptor accepted in cycle t gives ACTIVE lane, mux control and `message_en` visible at t+1.
- **Done latency.** `lane_done` in cycle t makes the lane IDLE at t+1. A new accept onto that lane can then occur at t+1, becoming ACTIVE at t+2.
- **Maximum hold.** Counting from the first ACTIVE cycle, a lane is ACTIVE for at most TIMEOUT cycles. `lane_timeout` is asserted in the first IDLE cycle (t+1 after `tcnt` reaches TIMEOUT-1), for exactly 1 cycle.
- **Throughput.** One descriptor per cycle while any lane is free. With all 3 lanes ACTIVE, `msg_ready = 0` for non-default types.
- **Counter saturation.** `drop_cnt` and `timeout_cnt` hold at 2^CNT_W−1 and do not wrap.

## Test plan
- **Reset state.** Hold `rst_n` low; check all outputs at their reset values, `msg_ready = 1`. Then, with `message_en = 1` mid-message, deassert-assert `rst_n` asynchronously; outputs must clear immediately.
- **Round-robin fill.** Back-to-back types 3, 5, 7 with no done:
  - m1=3, m2=5, m3=7, one cycle after each accept.
  - `msg_ready = 0` after the third accept.
  - Then `lane_done = 3'b010`: m2 → 0 next cycle, `msg_ready` rises, and the next type (9) lands on lane 2.
- **Drop path.** `msg_type = 0` while all lanes are busy: accepted (`msg_ready = 1`), no lane change, `drop_cnt` 0→1.
- **Timeout.** With TIMEOUT=4, grant lane 1 and never send done:
  - ACTIVE for exactly 4 cycles.
  - `lane_timeout = 3'b001` for 1 cycle; `timeout_cnt = 1`; m1 returns to 0.
  - Repeat with done in the 4th ACTIVE cycle: no pulse, count unchanged.
- **Simultaneous events and idle done.**
  - Done on lane 2 and a new accept in the same cycle, lanes 1 and 3 busy, lane 2 ACTIVE: the grant is refused that cycle (`msg_ready = 0`) and succeeds the next cycle.
  - `lane_done` on an IDLE lane: no effect.
- **Saturation.** Preload by forcing 0xFFFE, then drop 3 descriptors: `drop_cnt` ends at 0xFFFF.

Source files
------------

// File: rtl/stage5_lane_scheduler.sv
// Round-robin dispatch of message descriptors onto three field-extraction lanes with per-lane done/timeout release.
// Latency: accept in cycle t shows ACTIVE lane, mux control and message_en at t+1; lane_timeout pulses 1 cycle after release.
// Backpressure: msg_ready drops for non-default types while all lanes are ACTIVE; default-type descriptors are always accepted and dropped.
module stage5_lane_scheduler #(
   parameter int MUX_W       = 4,
   parameter int MUX_DEFAULT = 0,
   parameter int TIMEOUT     = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             msg_valid,
   input  logic [MUX_W-1:0] msg_type,
   output logic             msg_ready,
   input  logic [2:0]       lane_done,
   output logic             message_en,
   output logic [MUX_W-1:0] message_mux_control_m1,
   output logic [MUX_W-1:0] message_mux_control_m2,
   output logic [MUX_W-1:0] message_mux_control_m3,
   output logic [2:0]       lane_timeout,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [CNT_W-1:0] timeout_cnt
);

   localparam int               TW    = $clog2(TIMEOUT);
   localparam logic [MUX_W-1:0] DEF   = MUX_W'(MUX_DEFAULT);
   localparam logic [TW-1:0]    TLAST = TW'(TIMEOUT - 1);

   typedef enum logic {L_IDLE = 1'b0, L_ACTIVE = 1'b1} lane_st_t;

   lane_st_t         st_q   [3];
   lane_st_t         st_d   [3];
   logic [MUX_W-1:0] typ_q  [3];
   logic [MUX_W-1:0] typ_d  [3];
   logic [TW-1:0]    tcnt_q [3];
   logic [TW-1:0]    tcnt_d [3];
   logic [1:0]       rr_ptr_q, rr_ptr_d;
   logic [2:0]       lane_timeout_q, lane_timeout_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;

   logic [2:0]       idle_vec;
   logic [2:0]       gnt;
   logic             is_def;
   logic             accept;
   logic [1:0]       n_timeouts;
   logic [CNT_W:0]   to_sum;

   // First idle lane at or after rr, wrapping over the three lanes.
   function automatic logic [2:0] pick_lane(input logic [2:0] idle, input logic [1:0] rr);
      logic [2:0] g;
      g = '0;
      for (int k = 0; k < 3; k++) begin
         int idx;
         idx = (int'(rr) + k) % 3;
         if (g == 3'b000 && idle[idx]) g[idx] = 1'b1;
      end
      return g;
   endfunction

   // Ready and grant look only at registered lane state, so a lane freed this cycle is not reusable until the next.
   always_comb begin
      for (int i = 0; i < 3; i++) idle_vec[i] = (st_q[i] == L_IDLE);
      is_def    = (msg_type == DEF);
      msg_ready = is_def | (|idle_vec);
      accept    = msg_valid & msg_ready;
      gnt       = pick_lane(idle_vec, rr_ptr_q);
   end

   // Next-state for lanes, round-robin pointer and saturating statistics.
   always_comb begin
      rr_ptr_d       = rr_ptr_q;
      lane_timeout_d = '0;
      drop_cnt_d     = drop_cnt_q;
      for (int i = 0; i < 3; i++) begin
         st_d[i]   = st_q[i];
         typ_d[i]  = typ_q[i];
         tcnt_d[i] = tcnt_q[i];
         if (st_q[i] == L_ACTIVE) begin
            if (lane_done[i]) begin
               st_d[i]   = L_IDLE;
               typ_d[i]  = DEF;
               tcnt_d[i] = '0;
            end else if (tcnt_q[i] == TLAST) begin
               st_d[i]           = L_IDLE;
               typ_d[i]          = DEF;
               tcnt_d[i]         = '0;
               lane_timeout_d[i] = 1'b1;
            end else begin
               tcnt_d[i] = tcnt_q[i] + TW'(1);
            end
         end else if (accept && !is_def && gnt[i]) begin
            st_d[i]   = L_ACTIVE;
            typ_d[i]  = msg_type;
            tcnt_d[i] = '0;
            rr_ptr_d  = (i == 2) ? 2'd0 : 2'(i + 1);
         end
      end
      if (accept && is_def && drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + CNT_W'(1);
      n_timeouts = 2'({1'b0, lane_timeout_d[0]} + {1'b0, lane_timeout_d[1]} + {1'b0, lane_timeout_d[2]});
      to_sum     = {1'b0, timeout_cnt_q} + (CNT_W+1)'(n_timeouts);
      timeout_cnt_d = to_sum[CNT_W] ? {CNT_W{1'b1}} : to_sum[CNT_W-1:0];
   end

   // State registers; reset abandons in-flight messages without a timeout pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            st_q[i]   <= L_IDLE;
            typ_q[i]  <= DEF;
            tcnt_q[i] <= '0;
         end
         rr_ptr_q       <= 2'd0;
         lane_timeout_q <= '0;
         drop_cnt_q     <= '0;
         timeout_cnt_q  <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            st_q[i]   <= st_d[i];
            typ_q[i]  <= typ_d[i];
            tcnt_q[i] <= tcnt_d[i];
         end
         rr_ptr_q       <= rr_ptr_d;
         lane_timeout_q <= lane_timeout_d;
         drop_cnt_q     <= drop_cnt_d;
         timeout_cnt_q  <= timeout_cnt_d;
      end
   end

   // Outputs come straight from registers; idle lanes already hold the default code.
   assign message_en             = (st_q[0] == L_ACTIVE) | (st_q[1] == L_ACTIVE) | (st_q[2] == L_ACTIVE);
   assign message_mux_control_m1 = typ_q[0];
   assign message_mux_control_m2 = typ_q[1];
   assign message_mux_control_m3 = typ_q[2];
   assign lane_timeout           = lane_timeout_q;
   assign drop_cnt               = drop_cnt_q;
   assign timeout_cnt            = timeout_cnt_q;

endmodule
